// File: rtl/i2c_dac_if.sv
// Bus-side signals of the I2C DAC target: sensed SCL/SDA, open-drain SDA enable and
// received-value outputs. The slave modport is the DUT view.
interface i2c_dac_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe_o;
    logic [7:0] dac_value_o;
    logic [7:0] ctrl_reg_o;
    logic       data_valid_o;
    logic       busy_o;

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_oe_o,
        output dac_value_o,
        output ctrl_reg_o,
        output data_valid_o,
        output busy_o
    );

    modport master (
        output scl_i,
        output sda_i,
        input  sda_oe_o,
        input  dac_value_o,
        input  ctrl_reg_o,
        input  data_valid_o,
        input  busy_o
    );
endinterface

// File: rtl/i2c_dac_responder.sv
// I2C target model of the 8-bit DAC: address, control byte, then any number of data bytes.
// Define I2C_RESP_READ_EN to also answer read frames by shifting out dac_value.
module i2c_dac_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'h48,
    parameter logic [7:0] DATA_RESET = 8'h00,
    parameter logic [7:0] CTRL_RESET = 8'h40
) (
    input logic      clk_i,
    input logic      rst_i,
    i2c_dac_if.slave bus
);

`ifdef I2C_RESP_READ_EN
    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StCtrl, StCtrlAck, StData, StDataAck, StRdTx, StRdAck
    } state_e;
`else
    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StCtrl, StCtrlAck, StData, StDataAck
    } state_e;
`endif

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] dac_q, dac_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic       dv_q, dv_d;
    logic       busy_q, busy_d;
`ifdef I2C_RESP_READ_EN
    logic [7:0] tx_q, tx_d;
`endif

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, addr_ok;
    logic [7:0] byte_in;

    // Lines idle high, so the synchroniser resets to 1 to avoid phantom edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.scl_i};
            sda_sync_q <= {sda_sync_q[0], bus.sda_i};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    always_comb begin
        scl_s     = scl_sync_q[1];
        sda_s     = sda_sync_q[1];
        scl_rise  = scl_s & ~scl_hist_q;
        scl_fall  = ~scl_s & scl_hist_q;
        start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
        stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
        byte_in   = {shift_q[6:0], sda_s};
`ifdef I2C_RESP_READ_EN
        addr_ok   = (shift_q[7:1] == DEV_ADDR);
`else
        addr_ok   = (shift_q[7:1] == DEV_ADDR) & ~shift_q[0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        dac_d     = dac_q;
        ctrl_d    = ctrl_q;
        dv_d      = 1'b0;
        busy_d    = busy_q;
`ifdef I2C_RESP_READ_EN
        tx_d      = tx_q;
`endif
        // Bus conditions take priority over any bit activity in the same cycle.
        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr, StCtrl, StData: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && state_q == StCtrl) ctrl_d = byte_in;
                        if (bit_cnt_q == 4'd7 && state_q == StData) begin
                            dac_d = byte_in;
                            dv_d  = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b1;
                        if (state_q == StCtrl) begin
                            state_d = StCtrlAck;
                        end else if (state_q == StData) begin
                            state_d = StDataAck;
                        end else if (addr_ok) begin
                            state_d = StAddrAck;
                            busy_d  = 1'b1;
                        end else begin
                            state_d  = StIdle;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = StCtrl;
`ifdef I2C_RESP_READ_EN
                        if (shift_q[0]) begin
                            state_d  = StRdTx;
                            tx_d     = dac_q;
                            sda_oe_d = ~dac_q[7];
                        end
`endif
                    end
                end
                StCtrlAck, StDataAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = StData;
                    end
                end
`ifdef I2C_RESP_READ_EN
                StRdTx: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = StRdAck;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                StRdAck: begin
                    // bit_cnt marks a sampled master ACK until the closing falling edge.
                    if (scl_rise) begin
                        if (sda_s) state_d = StIdle;
                        else       bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd0;
                        state_d   = StRdTx;
                        tx_d      = dac_q;
                        sda_oe_d  = ~dac_q[7];
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            sda_oe_q  <= 1'b0;
            dac_q     <= DATA_RESET;
            ctrl_q    <= CTRL_RESET;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef I2C_RESP_READ_EN
            tx_q      <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sda_oe_q  <= sda_oe_d;
            dac_q     <= dac_d;
            ctrl_q    <= ctrl_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
`ifdef I2C_RESP_READ_EN
            tx_q      <= tx_d;
`endif
        end
    end

    assign bus.sda_oe_o     = sda_oe_q;
    assign bus.dac_value_o  = dac_q;
    assign bus.ctrl_reg_o   = ctrl_q;
    assign bus.data_valid_o = dv_q;
    assign bus.busy_o       = busy_q;

endmodule
